// File: rtl/register_pkg.sv
// Shared definitions for the register bank and the core control unit:
// write-operation encodings and their width.
package register_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    // True for the operations that step a register and can therefore wrap.
    function automatic logic is_step_op(input op_e op_in);
        return (op_in == OP_INC) || (op_in == OP_DEC);
    endfunction

endpackage

// File: rtl/register_next_value.sv
// Combinational next-value generator for one register: applies the selected
// write operation to the current value and reports whether a step wrapped.
module register_next_value
    import register_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] cur_value,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] next_value,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

    op_e op_s;
    logic edge_value_s;

    // Decode the operation and compute the post-op value plus wrap condition.
    always_comb begin
        op_s         = op_e'(op);
        next_value   = cur_value;
        edge_value_s = 1'b0;
        case (op_s)
            OP_LOAD: begin
                next_value   = data_in;
                edge_value_s = 1'b0;
            end
            OP_INC: begin
                next_value   = cur_value + ONE_W;
                edge_value_s = (cur_value == ONES_W);
            end
            OP_DEC: begin
                next_value   = cur_value - ONE_W;
                edge_value_s = (cur_value == ZERO_W);
            end
            OP_CLR: begin
                // Clear goes to zero, deliberately not to the reset value.
                next_value   = ZERO_W;
                edge_value_s = 1'b0;
            end
            default: begin
                next_value   = cur_value;
                edge_value_s = 1'b0;
            end
        endcase
        wrap = is_step_op(op_s) && edge_value_s;
    end

endmodule

// File: rtl/register_bank.sv
// Bank of DEPTH working registers behind a single write port (load, increment,
// decrement, clear) with two registered read ports. A read that hits the
// register being written this cycle returns the post-op value. Out-of-range
// addresses drop the write / read zero and raise a one-cycle addrErr pulse.
module register_bank
    import register_pkg::*;
#(
    parameter int               WIDTH       = 12,
    parameter int               DEPTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    localparam int              ADDR_W      = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              writeEn,
    input  logic [OP_W-1:0]   op,
    input  logic [ADDR_W-1:0] writeAddr,
    input  logic [WIDTH-1:0]  dataIn,
    input  logic [ADDR_W-1:0] readAddrA,
    input  logic [ADDR_W-1:0] readAddrB,
    output logic [WIDTH-1:0]  dataOutA,
    output logic [WIDTH-1:0]  dataOutB,
    output logic              wrapFlag,
    output logic              addrErr
);

    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};

    // An address is usable only below DEPTH; DEPTH need not be a power of two.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_L);
    endfunction

    logic [WIDTH-1:0] regs_r [0:DEPTH-1];

    logic             wr_valid_s;
    logic             rd_a_valid_s;
    logic             rd_b_valid_s;
    logic [WIDTH-1:0] cur_value_s;
    logic [WIDTH-1:0] stored_a_s;
    logic [WIDTH-1:0] stored_b_s;
    logic [WIDTH-1:0] next_value_s;
    logic             wrap_s;
    logic [WIDTH-1:0] rd_a_data_s;
    logic [WIDTH-1:0] rd_b_data_s;
    logic             err_s;

    // Address qualification for the write port and both read ports.
    always_comb begin
        wr_valid_s   = writeEn && addr_ok(writeAddr);
        rd_a_valid_s = addr_ok(readAddrA);
        rd_b_valid_s = addr_ok(readAddrB);
    end

    // Select the addressed registers without indexing past the array end.
    always_comb begin
        cur_value_s = ZERO_W;
        stored_a_s  = ZERO_W;
        stored_b_s  = ZERO_W;
        for (int i = 0; i < DEPTH; i++) begin
            cur_value_s = (writeAddr == ADDR_W'(i)) ? regs_r[i] : cur_value_s;
            stored_a_s  = (readAddrA == ADDR_W'(i)) ? regs_r[i] : stored_a_s;
            stored_b_s  = (readAddrB == ADDR_W'(i)) ? regs_r[i] : stored_b_s;
        end
    end

    register_next_value #(
        .WIDTH (WIDTH)
    ) u_next_value (
        .op         (op),
        .cur_value  (cur_value_s),
        .data_in    (dataIn),
        .next_value (next_value_s),
        .wrap       (wrap_s)
    );

    // Read data for the next edge: zero if out of range, forwarded if the
    // same register is being written now, otherwise the stored value.
    always_comb begin
        if (!rd_a_valid_s) begin
            rd_a_data_s = ZERO_W;
        end else if (wr_valid_s && (readAddrA == writeAddr)) begin
            rd_a_data_s = next_value_s;
        end else begin
            rd_a_data_s = stored_a_s;
        end

        if (!rd_b_valid_s) begin
            rd_b_data_s = ZERO_W;
        end else if (wr_valid_s && (readAddrB == writeAddr)) begin
            rd_b_data_s = next_value_s;
        end else begin
            rd_b_data_s = stored_b_s;
        end

        err_s = (writeEn && !addr_ok(writeAddr)) || !rd_a_valid_s || !rd_b_valid_s;
    end

    // Register storage: only the validly addressed register takes the op.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_valid_s && (writeAddr == ADDR_W'(i))) begin
                    regs_r[i] <= next_value_s;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Registered read data and status pulses; pulses last one cycle because
    // they are recomputed from scratch every edge.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            dataOutA <= RESET_VALUE;
            dataOutB <= RESET_VALUE;
            wrapFlag <= 1'b0;
            addrErr  <= 1'b0;
        end else begin
            dataOutA <= rd_a_data_s;
            dataOutB <= rd_b_data_s;
            wrapFlag <= wr_valid_s && wrap_s;
            addrErr  <= err_s;
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Directed testbench for register_bank (DEPTH=6, RESET_VALUE=12'h005) with
// hand-computed expected values, one task per feature.
module tb_register_bank;
    import register_pkg::*;

    localparam int WIDTH = 12;
    localparam int DEPTH = 6;
    localparam int AW    = 3;

    logic             clock;
    logic             rst;
    logic             writeEn;
    logic [1:0]       op;
    logic [AW-1:0]    writeAddr;
    logic [WIDTH-1:0] dataIn;
    logic [AW-1:0]    readAddrA;
    logic [AW-1:0]    readAddrB;
    logic [WIDTH-1:0] dataOutA;
    logic [WIDTH-1:0] dataOutB;
    logic             wrapFlag;
    logic             addrErr;

    int checks   = 0;
    int failures = 0;

    register_bank #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RESET_VALUE (12'h005)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .writeEn   (writeEn),
        .op        (op),
        .writeAddr (writeAddr),
        .dataIn    (dataIn),
        .readAddrA (readAddrA),
        .readAddrB (readAddrB),
        .dataOutA  (dataOutA),
        .dataOutB  (dataOutB),
        .wrapFlag  (wrapFlag),
        .addrErr   (addrErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; writeEn = 1'b0; op = OP_LOAD; writeAddr = 3'd0;
        dataIn = 12'h000; readAddrA = 3'd0; readAddrB = 3'd0;
        tick(); tick();
        checks++; if (dataOutA !== 12'h005) begin failures++; $display("FAIL reset_a got=%h exp=005", dataOutA); end
        checks++; if (dataOutB !== 12'h005) begin failures++; $display("FAIL reset_b got=%h exp=005", dataOutB); end
        checks++; if ({wrapFlag, addrErr} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {wrapFlag, addrErr}); end
        // Put non-reset values on the outputs, then reset mid-cycle.
        rst = 1'b1;
        writeEn = 1'b1; op = OP_LOAD; writeAddr = 3'd0; dataIn = 12'h3AA;
        readAddrA = 3'd0; readAddrB = 3'd7;
        tick();
        checks++; if (dataOutA !== 12'h3AA) begin failures++; $display("FAIL pre_reset_a got=%h exp=3aa", dataOutA); end
        checks++; if (addrErr !== 1'b1) begin failures++; $display("FAIL pre_reset_err got=%b exp=1", addrErr); end
        #3;
        rst = 1'b0;
        dataIn = 12'h111;
        #1;
        checks++; if (dataOutA !== 12'h005) begin failures++; $display("FAIL async_reset_a got=%h exp=005", dataOutA); end
        checks++; if (dataOutB !== 12'h005) begin failures++; $display("FAIL async_reset_b got=%h exp=005", dataOutB); end
        checks++; if ({wrapFlag, addrErr} !== 2'b00) begin failures++; $display("FAIL async_reset_flags got=%b exp=00", {wrapFlag, addrErr}); end
        tick();
        checks++; if (dataOutA !== 12'h005) begin failures++; $display("FAIL reset_held_a got=%h exp=005", dataOutA); end
        rst = 1'b1;
        writeEn = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            readAddrA = AW'(i);
            readAddrB = AW'(DEPTH - 1 - i);
            tick();
            checks++; if (dataOutA !== 12'h005) begin failures++; $display("FAIL reset_read_a[%0d] got=%h exp=005", i, dataOutA); end
            checks++; if (dataOutB !== 12'h005) begin failures++; $display("FAIL reset_read_b[%0d] got=%h exp=005", i, dataOutB); end
            checks++; if (addrErr !== 1'b0) begin failures++; $display("FAIL reset_read_err[%0d] got=%b exp=0", i, addrErr); end
        end
    endtask

    task automatic test_load_read();
        writeEn = 1'b1; op = OP_LOAD; writeAddr = 3'd3; dataIn = 12'h456;
        readAddrA = 3'd0; readAddrB = 3'd2;
        tick();
        checks++; if (dataOutA !== 12'h005) begin failures++; $display("FAIL load_other_a got=%h exp=005", dataOutA); end
        checks++; if ({wrapFlag, addrErr} !== 2'b00) begin failures++; $display("FAIL load_flags got=%b exp=00", {wrapFlag, addrErr}); end
        writeEn = 1'b0; readAddrA = 3'd3; readAddrB = 3'd2;
        tick();
        checks++; if (dataOutA !== 12'h456) begin failures++; $display("FAIL load_read_a got=%h exp=456", dataOutA); end
        checks++; if (dataOutB !== 12'h005) begin failures++; $display("FAIL load_reg2_b got=%h exp=005", dataOutB); end
    endtask

    task automatic test_forwarding();
        writeEn = 1'b1; op = OP_LOAD; writeAddr = 3'd5; dataIn = 12'h789;
        readAddrA = 3'd5; readAddrB = 3'd5;
        tick();
        checks++; if (dataOutA !== 12'h789) begin failures++; $display("FAIL fwd_load_a got=%h exp=789", dataOutA); end
        checks++; if (dataOutB !== 12'h789) begin failures++; $display("FAIL fwd_load_b got=%h exp=789", dataOutB); end
        op = OP_INC; readAddrB = 3'd3;
        tick();
        checks++; if (dataOutA !== 12'h78A) begin failures++; $display("FAIL fwd_inc_a got=%h exp=78a", dataOutA); end
        checks++; if (dataOutB !== 12'h456) begin failures++; $display("FAIL fwd_other_b got=%h exp=456", dataOutB); end
        writeEn = 1'b0;
    endtask

    task automatic test_wrap();
        writeEn = 1'b1; op = OP_LOAD; writeAddr = 3'd1; dataIn = 12'hFFF;
        readAddrA = 3'd1; readAddrB = 3'd0;
        tick();
        checks++; if (wrapFlag !== 1'b0) begin failures++; $display("FAIL wrap_load_fff got=%b exp=0", wrapFlag); end
        op = OP_INC;
        tick();
        checks++; if (dataOutA !== 12'h000) begin failures++; $display("FAIL wrap_inc_a got=%h exp=000", dataOutA); end
        checks++; if (wrapFlag !== 1'b1) begin failures++; $display("FAIL wrap_inc_flag got=%b exp=1", wrapFlag); end
        writeEn = 1'b0;
        tick();
        checks++; if (wrapFlag !== 1'b0) begin failures++; $display("FAIL wrap_pulse_end got=%b exp=0", wrapFlag); end
        checks++; if (dataOutA !== 12'h000) begin failures++; $display("FAIL wrap_hold_a got=%h exp=000", dataOutA); end
        writeEn = 1'b1; op = OP_DEC;
        tick();
        checks++; if (dataOutA !== 12'hFFF) begin failures++; $display("FAIL wrap_dec_a got=%h exp=fff", dataOutA); end
        checks++; if (wrapFlag !== 1'b1) begin failures++; $display("FAIL wrap_dec_flag got=%b exp=1", wrapFlag); end
        op = OP_LOAD; dataIn = 12'h010;
        tick();
        checks++; if (wrapFlag !== 1'b0) begin failures++; $display("FAIL wrap_load_010 got=%b exp=0", wrapFlag); end
        op = OP_INC;
        tick();
        checks++; if (dataOutA !== 12'h011) begin failures++; $display("FAIL inc_010_a got=%h exp=011", dataOutA); end
        checks++; if (wrapFlag !== 1'b0) begin failures++; $display("FAIL inc_010_flag got=%b exp=0", wrapFlag); end
        writeEn = 1'b0;
    endtask

    task automatic test_addr_err();
        // Registers now: 0=005 1=011 2=005 3=456 4=005 5=78A
        writeEn = 1'b1; op = OP_LOAD; writeAddr = 3'd7; dataIn = 12'h123;
        readAddrA = 3'd0; readAddrB = 3'd1;
        tick();
        checks++; if (addrErr !== 1'b1) begin failures++; $display("FAIL err_write7 got=%b exp=1", addrErr); end
        checks++; if (dataOutA !== 12'h005) begin failures++; $display("FAIL err_write7_a got=%h exp=005", dataOutA); end
        checks++; if (dataOutB !== 12'h011) begin failures++; $display("FAIL err_write7_b got=%h exp=011", dataOutB); end
        writeEn = 1'b0; readAddrA = 3'd2; readAddrB = 3'd3;
        tick();
        checks++; if (addrErr !== 1'b0) begin failures++; $display("FAIL err_pulse_end got=%b exp=0", addrErr); end
        checks++; if (dataOutA !== 12'h005) begin failures++; $display("FAIL err_reg2 got=%h exp=005", dataOutA); end
        checks++; if (dataOutB !== 12'h456) begin failures++; $display("FAIL err_reg3 got=%h exp=456", dataOutB); end
        readAddrA = 3'd4; readAddrB = 3'd5;
        tick();
        checks++; if (dataOutA !== 12'h005) begin failures++; $display("FAIL err_reg4 got=%h exp=005", dataOutA); end
        checks++; if (dataOutB !== 12'h78A) begin failures++; $display("FAIL err_reg5 got=%h exp=78a", dataOutB); end
        readAddrA = 3'd3; readAddrB = 3'd6;
        tick();
        checks++; if (dataOutB !== 12'h000) begin failures++; $display("FAIL err_read6_b got=%h exp=000", dataOutB); end
        checks++; if (addrErr !== 1'b1) begin failures++; $display("FAIL err_read6_flag got=%b exp=1", addrErr); end
        checks++; if (dataOutA !== 12'h456) begin failures++; $display("FAIL err_read6_a got=%h exp=456", dataOutA); end
        writeEn = 1'b1; op = OP_DEC; writeAddr = 3'd6; readAddrA = 3'd0; readAddrB = 3'd0;
        tick();
        checks++; if ({wrapFlag, addrErr} !== 2'b01) begin failures++; $display("FAIL err_dec6_flags got=%b exp=01", {wrapFlag, addrErr}); end
        checks++; if (dataOutA !== 12'h005) begin failures++; $display("FAIL err_dec6_a got=%h exp=005", dataOutA); end
        writeEn = 1'b0;
        tick();
        checks++; if (addrErr !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", addrErr); end
    endtask

    task automatic test_clr_hold();
        logic [WIDTH-1:0] exp_regs [0:DEPTH-1];
        exp_regs[0] = 12'h005; exp_regs[1] = 12'h011; exp_regs[2] = 12'h005;
        exp_regs[3] = 12'h456; exp_regs[4] = 12'h000; exp_regs[5] = 12'h78A;
        writeEn = 1'b1; op = OP_LOAD; writeAddr = 3'd4; dataIn = 12'hABC;
        readAddrA = 3'd4; readAddrB = 3'd2;
        tick();
        checks++; if (dataOutA !== 12'hABC) begin failures++; $display("FAIL clr_load_abc got=%h exp=abc", dataOutA); end
        op = OP_CLR;
        tick();
        checks++; if (dataOutA !== 12'h000) begin failures++; $display("FAIL clr_a got=%h exp=000", dataOutA); end
        checks++; if (dataOutB !== 12'h005) begin failures++; $display("FAIL clr_other_b got=%h exp=005", dataOutB); end
        writeEn = 1'b0; op = OP_INC; readAddrA = 3'd4; readAddrB = 3'd1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (wrapFlag !== 1'b0) begin failures++; $display("FAIL hold_wrap[%0d] got=%b exp=0", k, wrapFlag); end
            checks++; if (dataOutA !== 12'h000) begin failures++; $display("FAIL hold_a[%0d] got=%h exp=000", k, dataOutA); end
            checks++; if (dataOutB !== 12'h011) begin failures++; $display("FAIL hold_b[%0d] got=%h exp=011", k, dataOutB); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            readAddrA = AW'(i);
            readAddrB = AW'(i);
            tick();
            checks++; if (dataOutA !== exp_regs[i]) begin failures++; $display("FAIL final_a[%0d] got=%h exp=%h", i, dataOutA, exp_regs[i]); end
            checks++; if (dataOutB !== exp_regs[i]) begin failures++; $display("FAIL final_b[%0d] got=%h exp=%h", i, dataOutB, exp_regs[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_load_read();
        test_forwarding();
        test_wrap();
        test_addr_err();
        test_clr_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
